// File: rtl/xband_frame_ctrl.sv
// ---------------------------------------------------------------------------
// xband_frame_ctrl
//
// Frame sequencer in the sys_clk domain for the Xband MM2S/S2MM loopback path.
// A software start latches the expected byte count and pulses new_frame into
// the Xband block. The sequencer then watches both AXIS streams until S2MM
// tlast, a watchdog timeout, an overflow edge, a length error or an abort.
// Each finished frame raises a sticky irq. Successful frames increment
// frame_cnt.
//
// Ports
//   sys_clk, sys_rst      clock; asynchronous active-high reset
//   start, abort, irq_clr single-cycle software controls
//   frame_bytes [31:0]    expected payload, sampled on an accepted start
//   new_frame             frame-start strobe to Xband (NF_WIDTH cycles)
//   exp_bytes [31:0]      latched frame_bytes, drives Xband expBytes
//   data_cnt [31:0]       Xband S2MM received byte count
//   mm2s_overflow,
//   s2mm_overflow         Xband overflow levels (only rising edges in RUN count)
//   mm2s_t*, s2mm_t*      AXIS monitor taps
//   busy                  high in ARM and RUN
//   done                  one-cycle pulse on successful completion
//   irq                   sticky interrupt
//   status [5:0]          sticky {cfg_err, start_err, timeout, ovf, len_err, aborted}
//   tx_bytes [31:0]       bytes accepted on MM2S this frame
//   frame_cnt [CNT_W-1:0] successful frames, wraps
// ---------------------------------------------------------------------------
module xband_frame_ctrl #(
   parameter int unsigned NF_WIDTH = 4,
   parameter int unsigned TIMEOUT  = 1000000,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             start,
   input  logic             abort,
   input  logic             irq_clr,
   input  logic [31:0]      frame_bytes,
   output logic             new_frame,
   output logic [31:0]      exp_bytes,
   input  logic [31:0]      data_cnt,
   input  logic             mm2s_overflow,
   input  logic             s2mm_overflow,
   input  logic             mm2s_tvalid,
   input  logic             mm2s_tready,
   input  logic [3:0]       mm2s_tkeep,
   input  logic             s2mm_tvalid,
   input  logic             s2mm_tready,
   input  logic             s2mm_tlast,
   output logic             busy,
   output logic             done,
   output logic             irq,
   output logic [5:0]       status,
   output logic [31:0]      tx_bytes,
   output logic [CNT_W-1:0] frame_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_RUN,
      S_DONE,
      S_ERR
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [15:0] nf_cnt;
   logic [31:0] wd_cnt;
   logic [31:0] wd_nxt;
   logic        mm2s_ovf_p1;
   logic        s2mm_ovf_p1;
   logic [32:0] tx_sum;
   logic        mm2s_beat;
   logic        s2mm_beat;
   logic        ovf_rise;

   logic        accept;
   logic        done_set;
   logic        cfg_set;
   logic        start_set;
   logic        to_set;
   logic        ovf_set;
   logic        len_set;
   logic        abort_set;
   logic [5:0]  status_set;
   logic        irq_set;

   function automatic logic [2:0] popcount4(input logic [3:0] keep);
      popcount4 = 3'(keep[0]) + 3'(keep[1]) + 3'(keep[2]) + 3'(keep[3]);
   endfunction

   assign mm2s_beat = mm2s_tvalid & mm2s_tready;
   assign s2mm_beat = s2mm_tvalid & s2mm_tready;

   // One extra bit so the "would exceed" compare cannot wrap
   assign tx_sum = {1'b0, tx_bytes} + (mm2s_beat ? 33'(popcount4(mm2s_tkeep)) : 33'd0);

   // Any handshake on either stream counts as progress
   assign wd_nxt = (mm2s_beat | s2mm_beat) ? 32'd0 : wd_cnt + 32'd1;

   // Only edges count, so levels already high before RUN never trip an error
   assign ovf_rise = (mm2s_overflow & ~mm2s_ovf_p1) | (s2mm_overflow & ~s2mm_ovf_p1);

   assign start_set  = start && (state != S_IDLE);
   assign status_set = {cfg_set, start_set, to_set, ovf_set, len_set, abort_set};
   assign irq_set    = (|status_set) | done_set;

   // Outputs decode straight from registered state
   assign new_frame = (state == S_ARM);
   assign busy      = (state == S_ARM) || (state == S_RUN);
   assign done      = (state == S_DONE);

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      done_set  = 1'b0;
      cfg_set   = 1'b0;
      to_set    = 1'b0;
      ovf_set   = 1'b0;
      len_set   = 1'b0;
      abort_set = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (frame_bytes != 32'd0) begin
                  accept    = 1'b1;
                  state_nxt = S_ARM;
               end else begin
                  cfg_set = 1'b1;
               end
            end
         end
         S_ARM: begin
            if (abort) begin
               abort_set = 1'b1;
               state_nxt = S_ERR;
            end else if (nf_cnt == 16'(NF_WIDTH - 1)) begin
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            // Exit conditions in priority order; the first match wins
            if (abort) begin
               abort_set = 1'b1;
               state_nxt = S_ERR;
            end else if (ovf_rise) begin
               ovf_set   = 1'b1;
               state_nxt = S_ERR;
            end else if (tx_sum > {1'b0, exp_bytes}) begin
               len_set   = 1'b1;
               state_nxt = S_ERR;
            end else if ((TIMEOUT != 0) && (wd_nxt == 32'(TIMEOUT))) begin
               to_set    = 1'b1;
               state_nxt = S_ERR;
            end else if (s2mm_beat && s2mm_tlast) begin
               if ((data_cnt == exp_bytes) && (tx_sum[31:0] == exp_bytes)) begin
                  done_set  = 1'b1;
                  state_nxt = S_DONE;
               end else begin
                  len_set   = 1'b1;
                  state_nxt = S_ERR;
               end
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         S_ERR:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         exp_bytes   <= 32'd0;
         tx_bytes    <= 32'd0;
         status      <= 6'd0;
         irq         <= 1'b0;
         frame_cnt   <= '0;
         nf_cnt      <= 16'd0;
         wd_cnt      <= 32'd0;
         mm2s_ovf_p1 <= 1'b0;
         s2mm_ovf_p1 <= 1'b0;
      end else begin
         mm2s_ovf_p1 <= mm2s_overflow;
         s2mm_ovf_p1 <= s2mm_overflow;

         if (accept) begin
            exp_bytes <= frame_bytes;
            tx_bytes  <= 32'd0;
            wd_cnt    <= 32'd0;
            nf_cnt    <= 16'd0;
         end

         if (state == S_ARM) begin
            nf_cnt <= nf_cnt + 16'd1;
         end

         if (state == S_RUN) begin
            tx_bytes <= tx_sum[31:0];
            wd_cnt   <= wd_nxt;
         end

         if (done_set) begin
            frame_cnt <= frame_cnt + 1'b1;
         end

         // A clear (irq_clr or accepted start) loses to a same-cycle set
         if (accept || irq_clr) begin
            status <= status_set;
            irq    <= irq_set;
         end else begin
            status <= status | status_set;
            irq    <= irq | irq_set;
         end
      end
   end

endmodule

// File: tb/tb_xband_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_xband_frame_ctrl
//
// Directed scenarios followed by randomized traffic. A frame-level reference
// model tracks the expected outputs: countdown of strobe cycles, run flag,
// watchdog idle count, running byte total and sticky flags. Every cycle all
// outputs are compared against the model.
// ---------------------------------------------------------------------------
module tb_xband_frame_ctrl;

   localparam int NF    = 4;
   localparam int TO    = 50;
   localparam int CNT_W = 2;

   logic             sys_clk;
   logic             sys_rst;
   logic             start;
   logic             abort;
   logic             irq_clr;
   logic [31:0]      frame_bytes;
   logic             new_frame;
   logic [31:0]      exp_bytes;
   logic [31:0]      data_cnt;
   logic             mm2s_overflow;
   logic             s2mm_overflow;
   logic             mm2s_tvalid;
   logic             mm2s_tready;
   logic [3:0]       mm2s_tkeep;
   logic             s2mm_tvalid;
   logic             s2mm_tready;
   logic             s2mm_tlast;
   logic             busy;
   logic             done;
   logic             irq;
   logic [5:0]       status;
   logic [31:0]      tx_bytes;
   logic [CNT_W-1:0] frame_cnt;

   int n_checks;
   int n_errors;

   // Reference model state
   int          m_arm;     // strobe cycles still to come
   bit          m_run;
   int          m_fin;     // 0 none, 1 done cycle, 2 error cycle
   logic [31:0] m_exp;
   logic [31:0] m_tx;
   int          m_idle;
   logic [5:0]  m_status;
   bit          m_irq;
   int          m_cnt;
   bit          m_pmo;
   bit          m_pso;

   xband_frame_ctrl #(
      .NF_WIDTH (NF),
      .TIMEOUT  (TO),
      .CNT_W    (CNT_W)
   ) dut (
      .sys_clk       (sys_clk),
      .sys_rst       (sys_rst),
      .start         (start),
      .abort         (abort),
      .irq_clr       (irq_clr),
      .frame_bytes   (frame_bytes),
      .new_frame     (new_frame),
      .exp_bytes     (exp_bytes),
      .data_cnt      (data_cnt),
      .mm2s_overflow (mm2s_overflow),
      .s2mm_overflow (s2mm_overflow),
      .mm2s_tvalid   (mm2s_tvalid),
      .mm2s_tready   (mm2s_tready),
      .mm2s_tkeep    (mm2s_tkeep),
      .s2mm_tvalid   (s2mm_tvalid),
      .s2mm_tready   (s2mm_tready),
      .s2mm_tlast    (s2mm_tlast),
      .busy          (busy),
      .done          (done),
      .irq           (irq),
      .status        (status),
      .tx_bytes      (tx_bytes),
      .frame_cnt     (frame_cnt)
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, expv, $time);
      end
   endtask

   task automatic model_reset();
      m_arm    = 0;
      m_run    = 1'b0;
      m_fin    = 0;
      m_exp    = 32'd0;
      m_tx     = 32'd0;
      m_idle   = 0;
      m_status = 6'd0;
      m_irq    = 1'b0;
      m_cnt    = 0;
      m_pmo    = 1'b0;
      m_pso    = 1'b0;
   endtask

   // Advance the model by one clock using the currently driven inputs
   task automatic model_step();
      logic [5:0] set;
      bit         dn;
      bit         acc;
      bit         idle_now;
      bit         rise;
      int         nb;
      int         nidle;
      longint     ntx;
      if (sys_rst) begin
         model_reset();
         return;
      end
      set      = 6'd0;
      dn       = 1'b0;
      acc      = 1'b0;
      idle_now = (m_arm == 0) && !m_run && (m_fin == 0);
      if (start && !idle_now) set[4] = 1'b1;
      if (m_fin != 0) begin
         m_fin = 0;
      end else if (idle_now) begin
         if (start) begin
            if (frame_bytes != 0) begin
               acc    = 1'b1;
               m_exp  = frame_bytes;
               m_tx   = 32'd0;
               m_idle = 0;
               m_arm  = NF;
            end else begin
               set[5] = 1'b1;
            end
         end
      end else if (m_arm > 0) begin
         if (abort) begin
            set[0] = 1'b1;
            m_arm  = 0;
            m_fin  = 2;
         end else begin
            m_arm--;
            if (m_arm == 0) m_run = 1'b1;
         end
      end else begin
         nb    = (mm2s_tvalid && mm2s_tready) ? $countones(mm2s_tkeep) : 0;
         ntx   = longint'(m_tx) + longint'(nb);
         nidle = ((mm2s_tvalid && mm2s_tready) || (s2mm_tvalid && s2mm_tready)) ? 0 : m_idle + 1;
         rise  = (mm2s_overflow && !m_pmo) || (s2mm_overflow && !m_pso);
         if (abort) set[0] = 1'b1;
         else if (rise) set[2] = 1'b1;
         else if (ntx > longint'(m_exp)) set[1] = 1'b1;
         else if (nidle == TO) set[3] = 1'b1;
         else if (s2mm_tvalid && s2mm_tready && s2mm_tlast) begin
            if ((data_cnt == m_exp) && (ntx == longint'(m_exp))) dn = 1'b1;
            else set[1] = 1'b1;
         end
         if (dn) begin
            m_run = 1'b0;
            m_fin = 1;
            m_cnt++;
         end else if (set[3:0] != 4'd0) begin
            m_run = 1'b0;
            m_fin = 2;
         end
         m_tx   = 32'(ntx);
         m_idle = nidle;
      end
      m_pmo = mm2s_overflow;
      m_pso = s2mm_overflow;
      if (acc || irq_clr) begin
         m_status = set;
         m_irq    = (set != 6'd0) || dn;
      end else begin
         m_status = m_status | set;
         m_irq    = m_irq || (set != 6'd0) || dn;
      end
   endtask

   task automatic compare_all();
      check("new_frame", 32'(new_frame), 32'(m_arm > 0));
      check("busy", 32'(busy), 32'((m_arm > 0) || m_run));
      check("done", 32'(done), 32'(m_fin == 1));
      check("irq", 32'(irq), 32'(m_irq));
      check("status", 32'(status), 32'(m_status));
      check("exp_bytes", exp_bytes, m_exp);
      check("tx_bytes", tx_bytes, m_tx);
      check("frame_cnt", 32'(frame_cnt), 32'(m_cnt % (1 << CNT_W)));
   endtask

   // Called at a falling edge with inputs already driven
   task automatic step();
      model_step();
      @(posedge sys_clk);
      #1;
      compare_all();
      @(negedge sys_clk);
   endtask

   task automatic quiet_inputs();
      start       = 1'b0;
      abort       = 1'b0;
      irq_clr     = 1'b0;
      mm2s_tvalid = 1'b0;
      mm2s_tready = 1'b0;
      mm2s_tkeep  = 4'h0;
      s2mm_tvalid = 1'b0;
      s2mm_tready = 1'b0;
      s2mm_tlast  = 1'b0;
      data_cnt    = 32'd0;
   endtask

   // Start a frame and step through the strobe until RUN
   task automatic start_to_run(input logic [31:0] fb);
      int nfh;
      nfh         = 0;
      start       = 1'b1;
      frame_bytes = fb;
      step();
      if (new_frame) nfh++;
      start = 1'b0;
      repeat (NF) begin
         step();
         if (new_frame) nfh++;
      end
      check("nf_len", nfh, NF);
      check("run_busy", 32'(busy), 32'd1);
   endtask

   task automatic beat(input logic [3:0] keep, input bit last, input logic [31:0] dcnt);
      mm2s_tvalid = 1'b1;
      mm2s_tready = 1'b1;
      mm2s_tkeep  = keep;
      s2mm_tvalid = last;
      s2mm_tready = last;
      s2mm_tlast  = last;
      data_cnt    = dcnt;
      step();
      quiet_inputs();
   endtask

   initial begin
      int k;
      int quiet;
      int nb;
      n_checks      = 0;
      n_errors      = 0;
      quiet         = 0;
      sys_rst       = 1'b1;
      frame_bytes   = 32'd0;
      mm2s_overflow = 1'b0;
      s2mm_overflow = 1'b0;
      quiet_inputs();
      model_reset();

      repeat (3) @(posedge sys_clk);
      #1;
      check("rst_new_frame", 32'(new_frame), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_status", 32'(status), 32'd0);
      check("rst_exp", exp_bytes, 32'd0);
      check("rst_tx", tx_bytes, 32'd0);
      check("rst_cnt", 32'(frame_cnt), 32'd0);
      @(negedge sys_clk);
      sys_rst = 1'b0;
      step();

      // Basic 16-byte frame
      start_to_run(32'd16);
      beat(4'hF, 1'b0, 32'd4);
      beat(4'hF, 1'b0, 32'd8);
      beat(4'hF, 1'b0, 32'd12);
      beat(4'hF, 1'b1, 32'd16);
      check("f16_done", 32'(done), 32'd1);
      check("f16_tx", tx_bytes, 32'd16);
      check("f16_cnt", 32'(frame_cnt), 32'd1);
      check("f16_status", 32'(status), 32'd0);
      check("f16_irq", 32'(irq), 32'd1);
      step();
      check("f16_done_pulse", 32'(done), 32'd0);

      // Partial keep, then an overlong frame
      start_to_run(32'd6);
      beat(4'hF, 1'b0, 32'd4);
      beat(4'h3, 1'b1, 32'd6);
      check("f6_done", 32'(done), 32'd1);
      check("f6_tx", tx_bytes, 32'd6);
      step();
      start_to_run(32'd6);
      beat(4'hF, 1'b0, 32'd4);
      beat(4'h3, 1'b0, 32'd6);
      beat(4'h1, 1'b1, 32'd6);
      check("f7_status", 32'(status), 32'h02);
      check("f7_cnt", 32'(frame_cnt), 32'd2);
      check("f7_done", 32'(done), 32'd0);
      step();

      // Watchdog
      start_to_run(32'd8);
      k = 0;
      while (busy && k < 200) begin
         step();
         k++;
      end
      check("wd_cycles", k, TO);
      check("wd_status", 32'(status), 32'h08);
      check("wd_irq", 32'(irq), 32'd1);
      step();

      // Abort beats an overflow edge in the same cycle
      start_to_run(32'd8);
      abort         = 1'b1;
      s2mm_overflow = 1'b1;
      step();
      abort = 1'b0;
      check("prio_status", 32'(status), 32'h01);
      step();

      // Overflow levels high before start are not errors
      mm2s_overflow = 1'b1;
      step();
      start_to_run(32'd4);
      beat(4'hF, 1'b1, 32'd4);
      check("lvl_done", 32'(done), 32'd1);
      check("lvl_cnt", 32'(frame_cnt), 32'd3);
      step();
      mm2s_overflow = 1'b0;
      s2mm_overflow = 1'b0;
      step();

      // Zero-length start, clear, start during RUN
      frame_bytes = 32'd0;
      start       = 1'b1;
      step();
      start = 1'b0;
      check("cfg_status", 32'(status), 32'h20);
      check("cfg_irq", 32'(irq), 32'd1);
      check("cfg_no_nf", 32'(new_frame), 32'd0);
      step();
      check("cfg_idle", 32'(busy), 32'd0);
      irq_clr = 1'b1;
      step();
      irq_clr = 1'b0;
      check("clr_irq", 32'(irq), 32'd0);
      check("clr_status", 32'(status), 32'd0);
      start_to_run(32'd4);
      start       = 1'b1;
      frame_bytes = 32'd99;
      step();
      start = 1'b0;
      check("serr_status", 32'(status), 32'h10);
      check("serr_exp", exp_bytes, 32'd4);
      beat(4'hF, 1'b1, 32'd4);
      check("serr_done", 32'(done), 32'd1);
      check("wrap_cnt", 32'(frame_cnt), 32'd0);
      step();
      irq_clr = 1'b1;
      step();
      irq_clr = 1'b0;
      check("clr2_irq", 32'(irq), 32'd0);
      check("clr2_status", 32'(status), 32'd0);

      // Asynchronous reset in ARM
      frame_bytes = 32'd8;
      start       = 1'b1;
      step();
      start = 1'b0;
      step();
      sys_rst = 1'b1;
      #1;
      check("arst_new_frame", 32'(new_frame), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_exp", exp_bytes, 32'd0);
      model_reset();
      @(negedge sys_clk);
      step();
      sys_rst = 1'b0;
      step();

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         start       = ($urandom_range(0, 24) == 0);
         frame_bytes = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 12));
         abort       = ($urandom_range(0, 149) == 0);
         irq_clr     = ($urandom_range(0, 39) == 0);
         mm2s_tvalid = 1'($urandom_range(0, 1));
         mm2s_tready = ($urandom_range(0, 3) != 0);
         mm2s_tkeep  = 4'($urandom_range(0, 15));
         s2mm_tvalid = ($urandom_range(0, 3) == 0);
         s2mm_tready = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 99) == 0) mm2s_overflow = ~mm2s_overflow;
         if ($urandom_range(0, 99) == 0) s2mm_overflow = ~s2mm_overflow;
         if (quiet == 0 && $urandom_range(0, 299) == 0) quiet = 60;
         if (quiet > 0) begin
            quiet--;
            mm2s_tvalid = 1'b0;
            s2mm_tvalid = 1'b0;
         end
         nb = (mm2s_tvalid && mm2s_tready) ? $countones(mm2s_tkeep) : 0;
         if (longint'(m_tx) + longint'(nb) == longint'(m_exp) && $urandom_range(0, 3) != 0) begin
            s2mm_tvalid = 1'b1;
            s2mm_tready = 1'b1;
            s2mm_tlast  = 1'b1;
         end else begin
            s2mm_tlast = ($urandom_range(0, 15) == 0);
         end
         data_cnt = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 12)) : m_exp;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
